column_shift_acc: RTL and testbench
===================================

COLUMN_SHIFT_ACC -- requirements
Module: column_shift_acc

Interface
REQ-001 SHALL have parameter NUM_PE, default 16: number of PE lanes in the column.
REQ-002 SHALL have parameter SUM_W, default 10: signed PE partial-sum width per lane.
REQ-003 SHALL have parameter SHIFT_W, default 4: per-lane left-shift amount width.
REQ-004 SHALL have parameter ACC_W, default 28: signed accumulator and output width.
REQ-005 SHALL have parameter CNT_W, default 8: beat-counter width.
REQ-006 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port in_valid  input  1  input beat valid.
REQ-009 SHALL have port in_ready  output  1  block can accept a beat.
REQ-010 SHALL have port in_last  input  1  beat closes the current accumulation pass.
REQ-011 SHALL have port pe_sum  input  NUM_PE*SUM_W  packed signed lane sums; lane i at [i*SUM_W +: SUM_W].
REQ-012 SHALL have port shift  input  NUM_PE*SHIFT_W  packed unsigned lane shifts; lane i at [i*SHIFT_W +: SHIFT_W].
REQ-013 SHALL have port lane_en  input  NUM_PE  per-lane enable; 0 forces that lane's term to zero.
REQ-014 SHALL have port out_valid  output  1  total_output holds a completed pass.
REQ-015 SHALL have port out_ready  input  1  consumer accepts total_output.
REQ-016 SHALL have port total_output  output  ACC_W  signed saturated pass result.
REQ-017 SHALL have port sat_flag  output  1  saturation occurred during the pass.
REQ-018 SHALL have port beat_count  output  CNT_W  beats accepted in the pass.

Function
REQ-019 A beat SHALL be accepted iff in_valid && in_ready at a rising edge; pe_sum, shift, lane_en, in_last sampled only then.
REQ-020 Stage 1 SHALL register per lane term_i = lane_en[i] ? (sign-extended pe_sum_i << shift_i) : 0, width SUM_W + 2^SHIFT_W - 1, no truncation.
REQ-021 Stage 2 SHALL register the signed sum of all NUM_PE terms at full width (term width + clog2(NUM_PE)), no overflow.
REQ-022 Stage 3 SHALL compute acc + stage-2 sum at full width, clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1], and register into acc.
REQ-023 On a clamp, sat_flag SHALL be set and remain set until the pass is consumed.
REQ-024 FSM states: ACCUM (in_ready=1), DRAIN (in_ready=0, last beat in pipeline), HOLD (in_ready=0, out_valid=1).
REQ-025 ACCUM -> DRAIN on acceptance of a beat with in_last=1.
REQ-026 DRAIN -> HOLD when the last beat's stage-3 update has been written; a last beat accepted at edge t SHALL yield out_valid=1 after edge t+3.
REQ-027 HOLD -> ACCUM on out_valid && out_ready; on that edge acc, sat_flag, beat_count SHALL clear to 0.
REQ-028 In HOLD, total_output, sat_flag, beat_count SHALL remain stable while out_ready=0.
REQ-029 total_output SHALL equal acc at all times; out_valid=0 outside HOLD.
REQ-030 beat_count SHALL increment per accepted beat and saturate at 2^CNT_W-1.
REQ-031 A pass of one beat (in_last on first beat) SHALL behave as REQ-026.
REQ-032 Non-last beats SHALL issue back-to-back at one per cycle with no bubbles.
REQ-033 SHALL assume shift_i up to 2^SHIFT_W-1 inclusive; all shift values legal.

Reset
REQ-034 reset=1 at an edge SHALL clear state to ACCUM, all pipeline registers, acc, sat_flag, beat_count to 0; out_valid=0, in_ready=1 the following cycle.
REQ-035 reset SHALL take priority over any handshake in the same cycle; in-flight beats are discarded.

Verification
REQ-036 All 16 lanes pe_sum=1, shift=0, lane_en=all ones, one beat with in_last -> out_valid after 3 edges, total_output=16, beat_count=1, sat_flag=0.
REQ-037 Only lane 0 enabled, pe_sum=-3, shift=4, one last beat -> total_output=-48.
REQ-038 All lanes pe_sum=511, shift=15, one last beat -> total_output=134217727, sat_flag=1; all lanes -512, shift=15 -> -134217728, sat_flag=1.
REQ-039 Four back-to-back beats, all lanes pe_sum=2, shift=1, last on fourth -> total_output=256, beat_count=4, in_ready=0 from edge after 4th beat until consume.
REQ-040 Hold out_ready=0 for 5 cycles in HOLD -> outputs stable, in_ready=0; out_ready=1 -> next cycle in_ready=1, acc=0.
REQ-041 Assert reset during DRAIN -> no out_valid; next single-beat pass (lane 0 pe_sum=5, shift=0) -> total_output=5.

Source files
------------

// File: rtl/column_shift_acc.sv
// Column shift-accumulator: per-lane shifted partial sums are reduced
// and accumulated with saturation across a multi-beat pass.
module column_shift_acc #(
   parameter int NUM_PE  = 16,
   parameter int SUM_W   = 10,
   parameter int SHIFT_W = 4,
   parameter int ACC_W   = 28,
   parameter int CNT_W   = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       in_last,
   input  logic [NUM_PE*SUM_W-1:0]    pe_sum,
   input  logic [NUM_PE*SHIFT_W-1:0]  shift,
   input  logic [NUM_PE-1:0]          lane_en,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [ACC_W-1:0]           total_output,
   output logic                       sat_flag,
   output logic [CNT_W-1:0]           beat_count
);

   localparam int TERM_W = SUM_W + (1 << SHIFT_W) - 1;
   localparam int TOT_W  = TERM_W + $clog2(NUM_PE);
   localparam int EXT_W  = ((ACC_W > TOT_W) ? ACC_W : TOT_W) + 1;

   localparam logic signed [EXT_W-1:0] ACC_MAX =
      {{(EXT_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
   localparam logic signed [EXT_W-1:0] ACC_MIN =
      {{(EXT_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

   typedef enum logic [1:0] {
      ACCUM = 2'd0,
      DRAIN = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t state;

   logic accept;
   logic consume;
   logic v1, last1;
   logic v2, last2;
   logic last3;

   logic signed [TERM_W-1:0] term_next [NUM_PE];
   logic signed [TERM_W-1:0] term      [NUM_PE];
   logic signed [TOT_W-1:0]  tot_next;
   logic signed [TOT_W-1:0]  tot;
   logic signed [EXT_W-1:0]  acc_ext;
   logic signed [ACC_W-1:0]  acc;
   logic signed [ACC_W-1:0]  acc_next;
   logic                     clamp;

   assign accept       = in_valid && in_ready;
   assign consume      = out_valid && out_ready;
   assign total_output = acc;

   // Lane terms: sign-extend to full width first so the shift never truncates
   always_comb begin
      for (int i = 0; i < NUM_PE; i++) begin
         term_next[i] = '0;
         if (lane_en[i])
            term_next[i] = TERM_W'($signed(pe_sum[i*SUM_W +: SUM_W]))
                           <<< shift[i*SHIFT_W +: SHIFT_W];
      end
   end

   // Column reduction at full width; log2(NUM_PE) guard bits prevent overflow
   always_comb begin
      tot_next = '0;
      for (int i = 0; i < NUM_PE; i++)
         tot_next = tot_next + TOT_W'(term[i]);
   end

   // Accumulate at extended width, then clamp into the signed ACC_W range
   always_comb begin
      acc_ext  = EXT_W'(acc) + EXT_W'(tot);
      acc_next = acc_ext[ACC_W-1:0];
      clamp    = 1'b0;
      if (acc_ext > ACC_MAX) begin
         acc_next = ACC_MAX[ACC_W-1:0];
         clamp    = 1'b1;
      end else if (acc_ext < ACC_MIN) begin
         acc_next = ACC_MIN[ACC_W-1:0];
         clamp    = 1'b1;
      end
   end

   // Stage 1 and 2 pipeline registers with valid/last tags
   always_ff @(posedge clk) begin
      if (reset) begin
         v1    <= 1'b0;
         last1 <= 1'b0;
         v2    <= 1'b0;
         last2 <= 1'b0;
         last3 <= 1'b0;
         term  <= '{default: '0};
         tot   <= '0;
      end else begin
         v1    <= accept;
         last1 <= accept && in_last;
         if (accept)
            term <= term_next;
         v2    <= v1;
         last2 <= v1 && last1;
         if (v1)
            tot <= tot_next;
         last3 <= v2 && last2;
      end
   end

   // Stage 3 accumulator, sticky saturation and saturating beat counter
   always_ff @(posedge clk) begin
      if (reset) begin
         acc        <= '0;
         sat_flag   <= 1'b0;
         beat_count <= '0;
      end else if (consume) begin
         acc        <= '0;
         sat_flag   <= 1'b0;
         beat_count <= '0;
      end else begin
         if (v2) begin
            acc <= acc_next;
            if (clamp)
               sat_flag <= 1'b1;
         end
         if (accept && (beat_count != '1))
            beat_count <= beat_count + CNT_W'(1);
      end
   end

   // Pass control: accept beats, drain the pipeline, hold result until taken
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ACCUM;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         unique case (state)
            ACCUM: begin
               if (accept && in_last) begin
                  state    <= DRAIN;
                  in_ready <= 1'b0;
               end
            end
            DRAIN: begin
               if (last3) begin
                  state     <= HOLD;
                  out_valid <= 1'b1;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state     <= ACCUM;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= ACCUM;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_column_shift_acc.sv
// Directed bench for column_shift_acc: table of passes plus
// hand-written sequences for sticky saturation and reset in DRAIN.
module tb_column_shift_acc;

   localparam int NP  = 16;
   localparam int SWD = 10;
   localparam int SHW = 4;
   localparam int AW  = 28;
   localparam int CW  = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic              in_valid;
   logic              in_ready;
   logic              in_last;
   logic [NP*SWD-1:0] pe_sum;
   logic [NP*SHW-1:0] shift;
   logic [NP-1:0]     lane_en;
   logic              out_valid;
   logic              out_ready;
   logic [AW-1:0]     total_output;
   logic              sat_flag;
   logic [CW-1:0]     beat_count;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   column_shift_acc #(
      .NUM_PE(NP), .SUM_W(SWD), .SHIFT_W(SHW), .ACC_W(AW), .CNT_W(CW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_last(in_last),
      .pe_sum(pe_sum),
      .shift(shift),
      .lane_en(lane_en),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .total_output(total_output),
      .sat_flag(sat_flag),
      .beat_count(beat_count)
   );

   typedef struct {
      string             name;
      logic [NP*SWD-1:0] s;
      logic [NP*SHW-1:0] sh;
      logic [NP-1:0]     en;
      int                beats;
      int                hold;
      longint            exp_tot;
      longint            exp_sat;
      longint            exp_cnt;
   } vec_t;

   vec_t tbl [7];

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic longint tot_s();
      return longint'($signed(total_output));
   endfunction

   function automatic logic [NP*SWD-1:0] rep_s(input int v);
      logic [NP*SWD-1:0] r;
      for (int i = 0; i < NP; i++)
         r[i*SWD +: SWD] = SWD'(v);
      return r;
   endfunction

   function automatic logic [NP*SHW-1:0] rep_sh(input int v);
      logic [NP*SHW-1:0] r;
      for (int i = 0; i < NP; i++)
         r[i*SHW +: SHW] = SHW'(v);
      return r;
   endfunction

   // Drive one beat; ready must already be high
   task automatic beat(input string nm, input logic [NP*SWD-1:0] s,
                       input logic [NP*SHW-1:0] sh, input logic [NP-1:0] en,
                       input logic last);
      chk({nm, "_in_ready"}, longint'(in_ready), 1);
      pe_sum   = s;
      shift    = sh;
      lane_en  = en;
      in_valid = 1'b1;
      in_last  = last;
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Called right after the edge accepting the last beat
   task automatic finish_pass(input string nm, input int hold,
                              input longint et, input longint es,
                              input longint ec);
      int lat;
      lat = 0;
      chk({nm, "_drain_ready"}, longint'(in_ready), 0);
      while (!out_valid && lat < 10) begin
         step();
         lat++;
      end
      chk({nm, "_latency"}, longint'(lat), 3);
      chk({nm, "_total"}, tot_s(), et);
      chk({nm, "_sat"}, longint'(sat_flag), es);
      chk({nm, "_count"}, longint'(beat_count), ec);
      for (int h = 0; h < hold; h++) begin
         pe_sum   = rep_s(511);
         shift    = rep_sh(15);
         lane_en  = '1;
         in_valid = 1'b1;
         in_last  = 1'b1;
         step();
         chk({nm, "_hold_valid"}, longint'(out_valid), 1);
         chk({nm, "_hold_ready"}, longint'(in_ready), 0);
         chk({nm, "_hold_total"}, tot_s(), et);
         chk({nm, "_hold_sat"}, longint'(sat_flag), es);
         chk({nm, "_hold_count"}, longint'(beat_count), ec);
      end
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk({nm, "_post_valid"}, longint'(out_valid), 0);
      chk({nm, "_post_ready"}, longint'(in_ready), 1);
      chk({nm, "_post_total"}, tot_s(), 0);
      chk({nm, "_post_sat"}, longint'(sat_flag), 0);
      chk({nm, "_post_count"}, longint'(beat_count), 0);
   endtask

   task automatic run(input vec_t v);
      for (int b = 0; b < v.beats; b++)
         beat(v.name, v.s, v.sh, v.en, logic'(b == v.beats - 1));
      finish_pass(v.name, v.hold, v.exp_tot, v.exp_sat, v.exp_cnt);
   endtask

   initial begin
      logic [NP*SWD-1:0] s;
      logic [NP*SHW-1:0] sh;
      bit                seen;

      tbl[0] = '{"ones", rep_s(1), rep_sh(0), 16'hFFFF, 1, 0,
                 16, 0, 1};
      s = rep_s(100);
      s[SWD-1:0] = SWD'(-3);
      tbl[1] = '{"lane0_neg", s, rep_sh(4), 16'h0001, 1, 0,
                 -48, 0, 1};
      tbl[2] = '{"pos_clamp", rep_s(511), rep_sh(15), 16'hFFFF, 1, 0,
                 134217727, 1, 1};
      tbl[3] = '{"neg_clamp", rep_s(-512), rep_sh(15), 16'hFFFF, 1, 0,
                 -134217728, 1, 1};
      for (int i = 0; i < NP; i++) begin
         s[i*SWD +: SWD] = SWD'(i - 8);
         sh[i*SHW +: SHW] = SHW'(i % 4);
      end
      tbl[4] = '{"mixed", s, sh, 16'hFFFF, 1, 0,
                 16, 0, 1};
      tbl[5] = '{"b2b4", rep_s(2), rep_sh(1), 16'hFFFF, 4, 5,
                 256, 0, 4};
      tbl[6] = '{"cnt_sat", rep_s(7), rep_sh(3), 16'h0000, 300, 0,
                 0, 0, 255};

      reset     = 1'b1;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      pe_sum    = '0;
      shift     = '0;
      lane_en   = '0;
      step();
      step();
      reset = 1'b0;
      chk("rst_in_ready", longint'(in_ready), 1);
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_total", tot_s(), 0);
      chk("rst_sat", longint'(sat_flag), 0);
      chk("rst_count", longint'(beat_count), 0);

      for (int k = 0; k < 7; k++)
         run(tbl[k]);

      // Saturation stays sticky after the accumulator leaves the rail
      beat("sticky", rep_s(511), rep_sh(15), '1, 1'b0);
      beat("sticky", rep_s(-1), rep_sh(0), '1, 1'b1);
      finish_pass("sticky", 1, 134217711, 1, 2);

      // Reset while the last beat is still draining
      beat("rst_drain", rep_s(1), rep_sh(0), '1, 1'b1);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rst_drain_ready", longint'(in_ready), 1);
      chk("rst_drain_total", tot_s(), 0);
      chk("rst_drain_count", longint'(beat_count), 0);
      seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
         if (out_valid)
            seen = 1'b1;
         step();
      end
      chk("rst_drain_no_valid", longint'(seen), 0);
      s = '0;
      s[SWD-1:0] = SWD'(5);
      beat("after_rst", s, rep_sh(0), 16'h0001, 1'b1);
      finish_pass("after_rst", 0, 5, 0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
